// File: rtl/tlc_phase_sched.sv
// Phase scheduler for the traffic-light controller: NS/EW phases with all-red clearance,
// latched pedestrian walk service and an emergency all-red hold, paced by a prescaled tick.
module tlc_phase_sched #(
  parameter int CNT_W    = 8,
  parameter int GREEN_T  = 10,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       emerg,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_ARN  = 3'd0,
    S_NSG  = 3'd1,
    S_NSY  = 3'd2,
    S_ARE  = 3'd3,
    S_EWG  = 3'd4,
    S_EWY  = 3'd5,
    S_WALK = 3'd6,
    S_EMRG = 3'd7
  } state_t;

  localparam logic [2:0] LIGHT_R = 3'b100;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_G = 3'b001;
  localparam logic       NXT_NS  = 1'b0;
  localparam logic       NXT_EW  = 1'b1;

  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(WALK_T - 1);

  state_t           state_r, state_next_s;
  logic [CNT_W-1:0] timer_r, timer_next_s;
  logic             nxt_r, nxt_next_s;
  logic             ped_pending_r, ped_pending_next_s;
  logic [2:0]       ns_light_r, ew_light_r, ns_light_s, ew_light_s;
  logic             walk_r, walk_s;
  logic             expire_s;

  assign expire_s = tick && (timer_r == '0);

  // State, timer, pedestrian latch and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= S_ARN;
      timer_r       <= LD_ALLRED;
      nxt_r         <= NXT_NS;
      ped_pending_r <= 1'b0;
      ns_light_r    <= LIGHT_R;
      ew_light_r    <= LIGHT_R;
      walk_r        <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      timer_r       <= timer_next_s;
      nxt_r         <= nxt_next_s;
      ped_pending_r <= ped_pending_next_s;
      ns_light_r    <= ns_light_s;
      ew_light_r    <= ew_light_s;
      walk_r        <= walk_s;
    end
  end

  // Next-state, timer reload and pedestrian latch; emergency outranks tick.
  always_comb begin
    state_next_s = state_r;
    nxt_next_s   = nxt_r;
    timer_next_s = (tick && (timer_r != '0)) ? (timer_r - CNT_W'(1)) : timer_r;
    case (state_r)
      S_ARN, S_ARE: begin
        if (emerg) begin
          state_next_s = S_EMRG;
        end else if (expire_s && ped_pending_r) begin
          state_next_s = S_WALK;
          timer_next_s = LD_WALK;
          nxt_next_s   = (state_r == S_ARN) ? NXT_NS : NXT_EW;
        end else if (expire_s) begin
          state_next_s = (state_r == S_ARN) ? S_NSG : S_EWG;
          timer_next_s = LD_GREEN;
        end else begin
          state_next_s = state_r;
        end
      end
      S_NSG, S_EWG: begin
        if (emerg || expire_s) begin
          state_next_s = (state_r == S_NSG) ? S_NSY : S_EWY;
          timer_next_s = LD_YELLOW;
        end else begin
          state_next_s = state_r;
        end
      end
      S_NSY, S_EWY: begin
        if (expire_s) begin
          state_next_s = (state_r == S_NSY) ? S_ARE : S_ARN;
          timer_next_s = LD_ALLRED;
        end else begin
          state_next_s = state_r;
        end
      end
      S_WALK: begin
        if (emerg) begin
          state_next_s = S_EMRG;
        end else if (expire_s) begin
          state_next_s = (nxt_r == NXT_NS) ? S_NSG : S_EWG;
          timer_next_s = LD_GREEN;
        end else begin
          state_next_s = state_r;
        end
      end
      S_EMRG: begin
        if (tick && !emerg) begin
          state_next_s = S_ARN;
          timer_next_s = LD_ALLRED;
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = S_ARN;
        timer_next_s = LD_ALLRED;
      end
    endcase

    // Entering WALK serves the request; an emergency abort out of WALK still latches a press.
    if ((state_next_s == S_WALK) && (state_r != S_WALK)) begin
      ped_pending_next_s = 1'b0;
    end else if (ped_req && ((state_r != S_WALK) || emerg)) begin
      ped_pending_next_s = 1'b1;
    end else begin
      ped_pending_next_s = ped_pending_r;
    end
  end

  // Light decode of the upcoming state, so the registered lamps track the state register.
  always_comb begin
    ns_light_s = LIGHT_R;
    ew_light_s = LIGHT_R;
    walk_s     = 1'b0;
    case (state_next_s)
      S_NSG:   ns_light_s = LIGHT_G;
      S_NSY:   ns_light_s = LIGHT_Y;
      S_EWG:   ew_light_s = LIGHT_G;
      S_EWY:   ew_light_s = LIGHT_Y;
      S_WALK:  walk_s     = 1'b1;
      default: begin
        ns_light_s = LIGHT_R;
        ew_light_s = LIGHT_R;
      end
    endcase
  end

  assign ns_light    = ns_light_r;
  assign ew_light    = ew_light_r;
  assign walk        = walk_r;
  assign ped_pending = ped_pending_r;
  assign state_o     = state_r;

endmodule

// File: tb/tb_tlc_phase_sched.sv
// Directed bench for tlc_phase_sched: phase timing, walk service, emergency and async reset.
module tb_tlc_phase_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       ped_req;
  logic       emerg;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_pending;
  logic [2:0] state_o;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  tlc_phase_sched dut (
    .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .emerg(emerg),
    .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
    .ped_pending(ped_pending), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic [2:0] ns,
                           input logic [2:0] ew, input logic wk, input logic pp);
    check({tag, ".state"}, {5'd0, state_o}, {5'd0, st});
    check({tag, ".ns"}, {5'd0, ns_light}, {5'd0, ns});
    check({tag, ".ew"}, {5'd0, ew_light}, {5'd0, ew});
    check({tag, ".walk"}, {7'd0, walk}, {7'd0, wk});
    check({tag, ".ped"}, {7'd0, ped_pending}, {7'd0, pp});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; ped_req = 1'b0; emerg = 1'b0;
    idle(2);
    check_all("reset", 3'd0, R, R, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0;

    // 1: plain cycle
    ticks(1);   check_all("t1.nsg", 3'd1, G, R, 1'b0, 1'b0);
    ticks(9);   check_all("t1.nsg_end", 3'd1, G, R, 1'b0, 1'b0);
    ticks(1);   check_all("t1.nsy", 3'd2, Y, R, 1'b0, 1'b0);
    ticks(3);   check_all("t1.are", 3'd3, R, R, 1'b0, 1'b0);
    ticks(1);   check_all("t1.ewg", 3'd4, R, G, 1'b0, 1'b0);
    ticks(10);  check_all("t1.ewy", 3'd5, R, Y, 1'b0, 1'b0);
    ticks(3);   check_all("t1.arn_28", 3'd0, R, R, 1'b0, 1'b0);

    // 2: pedestrian during NSG, served at ARE
    ticks(1);
    ped_req = 1'b1; idle(1); ped_req = 1'b0;
    check_all("t2.latched", 3'd1, G, R, 1'b0, 1'b1);
    ticks(9);   check_all("t2.green_kept", 3'd1, G, R, 1'b0, 1'b1);
    ticks(1);   check_all("t2.nsy", 3'd2, Y, R, 1'b0, 1'b1);
    ticks(3);   check_all("t2.are", 3'd3, R, R, 1'b0, 1'b1);
    ticks(1);   check_all("t2.walk", 3'd6, R, R, 1'b1, 1'b0);
    ticks(5);   check_all("t2.walk_end", 3'd6, R, R, 1'b1, 1'b0);
    ticks(1);   check_all("t2.ewg", 3'd4, R, G, 1'b0, 1'b0);

    // 3: emergency mid-EWG without tick
    emerg = 1'b1;
    idle(1);    check_all("t3.ewy", 3'd5, R, Y, 1'b0, 1'b0);
    ticks(2);   check_all("t3.ewy_run", 3'd5, R, Y, 1'b0, 1'b0);
    ticks(1);   check_all("t3.arn", 3'd0, R, R, 1'b0, 1'b0);
    idle(1);    check_all("t3.emrg", 3'd7, R, R, 1'b0, 1'b0);
    ticks(20);  check_all("t3.hold", 3'd7, R, R, 1'b0, 1'b0);
    emerg = 1'b0;
    idle(1);    check_all("t3.wait_tick", 3'd7, R, R, 1'b0, 1'b0);
    ticks(1);   check_all("t3.arn2", 3'd0, R, R, 1'b0, 1'b0);
    ticks(1);   check_all("t3.nsg", 3'd1, G, R, 1'b0, 1'b0);

    // 4: emergency during WALK with simultaneous request
    ped_req = 1'b1; idle(1); ped_req = 1'b0;
    ticks(10);  ticks(3);
    ticks(1);   check_all("t4.walk", 3'd6, R, R, 1'b1, 1'b0);
    ticks(2);
    emerg = 1'b1; ped_req = 1'b1;
    idle(1);    check_all("t4.emrg", 3'd7, R, R, 1'b0, 1'b1);
    emerg = 1'b0; ped_req = 1'b0;
    ticks(1);   check_all("t4.arn", 3'd0, R, R, 1'b0, 1'b1);
    ticks(1);   check_all("t4.walk2", 3'd6, R, R, 1'b1, 1'b0);
    ticks(5);   check_all("t4.walk2_end", 3'd6, R, R, 1'b1, 1'b0);
    ticks(1);   check_all("t4.nsg", 3'd1, G, R, 1'b0, 1'b0);

    // 5: async reset mid-NSY, away from any edge
    ped_req = 1'b1; idle(1); ped_req = 1'b0;
    ticks(10);
    ticks(1);   check_all("t5.nsy", 3'd2, Y, R, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1          check_all("t5.async_rst", 3'd0, R, R, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    #6;

    // 6: ped_req held continuously
    ped_req = 1'b1;
    idle(1);    check_all("t6.latch", 3'd0, R, R, 1'b0, 1'b1);
    ticks(1);   check_all("t6.walk_ns", 3'd6, R, R, 1'b1, 1'b0);
    ticks(5);   check_all("t6.ignored", 3'd6, R, R, 1'b1, 1'b0);
    ticks(1);   check_all("t6.nsg", 3'd1, G, R, 1'b0, 1'b0);
    idle(1);    check_all("t6.reset", 3'd1, G, R, 1'b0, 1'b1);
    ticks(10);  ticks(3);
    ticks(1);   check_all("t6.walk_ew", 3'd6, R, R, 1'b1, 1'b0);
    ticks(6);   check_all("t6.ewg", 3'd4, R, G, 1'b0, 1'b0);
    ped_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
